// File: rtl/axi_clint_mem_xbar_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) shared by the upstream port and both downstream ports.
interface axi_clint_mem_xbar_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    r_valid;
  logic                    r_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [1:0]              r_resp;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_resp, r_data, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_resp, r_data, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi_clint_mem_xbar.sv
// 1-to-2 AXI4 address demux: CLINT hits go to m1, everything else to m0.
// Independent read/write paths, one outstanding transaction each, zero added latency.
module axi_clint_mem_xbar #(
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                AXI_ID_WIDTH   = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0]  CLINT_BASE     = 32'h0200_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]  CLINT_MASK     = 32'hFFFF_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_clint_mem_xbar_if.slave    s,
  axi_clint_mem_xbar_if.master   m0,
  axi_clint_mem_xbar_if.master   m1
);

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  rstate_t rstate, rnext;
  wstate_t wstate, wnext;
  logic    rsel, wsel;
  logic    ar_sel, aw_sel;

  logic                      ar_ready_mux, aw_ready_mux, w_ready_mux;
  logic                      r_valid_mux, r_last_mux, b_valid_mux;
  logic [AXI_DATA_WIDTH-1:0] r_data_mux;
  logic [AXI_ID_WIDTH-1:0]   r_id_mux, b_id_mux;
  logic [1:0]                r_resp_mux, b_resp_mux;
  logic                      ar_hs, r_done, aw_hs, w_done, b_done;

  assign ar_sel = (s.ar_addr & CLINT_MASK) == CLINT_BASE;
  assign aw_sel = (s.aw_addr & CLINT_MASK) == CLINT_BASE;

  assign ar_ready_mux = ar_sel ? m1.ar_ready : m0.ar_ready;
  assign aw_ready_mux = aw_sel ? m1.aw_ready : m0.aw_ready;
  assign w_ready_mux  = wsel   ? m1.w_ready  : m0.w_ready;
  assign r_valid_mux  = rsel   ? m1.r_valid  : m0.r_valid;
  assign r_last_mux   = rsel   ? m1.r_last   : m0.r_last;
  assign r_data_mux   = rsel   ? m1.r_data   : m0.r_data;
  assign r_id_mux     = rsel   ? m1.r_id     : m0.r_id;
  assign r_resp_mux   = rsel   ? m1.r_resp   : m0.r_resp;
  assign b_valid_mux  = wsel   ? m1.b_valid  : m0.b_valid;
  assign b_id_mux     = wsel   ? m1.b_id     : m0.b_id;
  assign b_resp_mux   = wsel   ? m1.b_resp   : m0.b_resp;

  assign ar_hs  = (rstate == R_IDLE) && s.ar_valid && ar_ready_mux;
  assign r_done = (rstate == R_DATA) && r_valid_mux && s.r_ready && r_last_mux;
  assign aw_hs  = (wstate == W_IDLE) && s.aw_valid && aw_ready_mux;
  assign w_done = (wstate == W_DATA) && s.w_valid && w_ready_mux && s.w_last;
  assign b_done = (wstate == W_RESP) && b_valid_mux && s.b_ready;

  // Response payload back to the master from the slave owning the transaction.
  assign s.r_data = r_data_mux;
  assign s.r_id   = r_id_mux;
  assign s.r_resp = r_resp_mux;
  assign s.r_last = r_last_mux;
  assign s.b_id   = b_id_mux;
  assign s.b_resp = b_resp_mux;

  // Request payload is broadcast; only valid/ready are steered.
  assign m0.ar_id = s.ar_id;  assign m1.ar_id = s.ar_id;
  assign m0.ar_addr = s.ar_addr;  assign m1.ar_addr = s.ar_addr;
  assign m0.ar_len = s.ar_len;  assign m1.ar_len = s.ar_len;
  assign m0.ar_size = s.ar_size;  assign m1.ar_size = s.ar_size;
  assign m0.ar_burst = s.ar_burst;  assign m1.ar_burst = s.ar_burst;
  assign m0.aw_id = s.aw_id;  assign m1.aw_id = s.aw_id;
  assign m0.aw_addr = s.aw_addr;  assign m1.aw_addr = s.aw_addr;
  assign m0.aw_len = s.aw_len;  assign m1.aw_len = s.aw_len;
  assign m0.aw_size = s.aw_size;  assign m1.aw_size = s.aw_size;
  assign m0.aw_burst = s.aw_burst;  assign m1.aw_burst = s.aw_burst;
  assign m0.w_data = s.w_data;  assign m1.w_data = s.w_data;
  assign m0.w_strb = s.w_strb;  assign m1.w_strb = s.w_strb;
  assign m0.w_last = s.w_last;  assign m1.w_last = s.w_last;

  // State registers and the slave selection captured at the address handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rstate <= R_IDLE;
      wstate <= W_IDLE;
      rsel   <= 1'b0;
      wsel   <= 1'b0;
    end else begin
      rstate <= rnext;
      wstate <= wnext;
      if (ar_hs) rsel <= ar_sel;
      if (aw_hs) wsel <= aw_sel;
    end
  end

  // Read next-state: leave R_DATA only on the accepted last beat.
  always_comb begin
    rnext = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs)  rnext = R_DATA;
      R_DATA:  if (r_done) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  // Read handshake steering; everything forced low while in reset.
  always_comb begin
    m0.ar_valid = 1'b0;
    m1.ar_valid = 1'b0;
    s.ar_ready  = 1'b0;
    s.r_valid   = 1'b0;
    m0.r_ready  = 1'b0;
    m1.r_ready  = 1'b0;
    if (rst) begin
      unique case (rstate)
        R_IDLE: begin
          m0.ar_valid = s.ar_valid & ~ar_sel;
          m1.ar_valid = s.ar_valid & ar_sel;
          s.ar_ready  = ar_ready_mux;
        end
        R_DATA: begin
          s.r_valid  = r_valid_mux;
          m0.r_ready = s.r_ready & ~rsel;
          m1.r_ready = s.r_ready & rsel;
        end
        default: ;
      endcase
    end
  end

  // Write next-state: AW, then W beats until last, then the single B.
  always_comb begin
    wnext = wstate;
    unique case (wstate)
      W_IDLE:  if (aw_hs)  wnext = W_DATA;
      W_DATA:  if (w_done) wnext = W_RESP;
      W_RESP:  if (b_done) wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
  end

  // Write handshake steering; everything forced low while in reset.
  always_comb begin
    m0.aw_valid = 1'b0;
    m1.aw_valid = 1'b0;
    s.aw_ready  = 1'b0;
    m0.w_valid  = 1'b0;
    m1.w_valid  = 1'b0;
    s.w_ready   = 1'b0;
    s.b_valid   = 1'b0;
    m0.b_ready  = 1'b0;
    m1.b_ready  = 1'b0;
    if (rst) begin
      unique case (wstate)
        W_IDLE: begin
          m0.aw_valid = s.aw_valid & ~aw_sel;
          m1.aw_valid = s.aw_valid & aw_sel;
          s.aw_ready  = aw_ready_mux;
        end
        W_DATA: begin
          m0.w_valid = s.w_valid & ~wsel;
          m1.w_valid = s.w_valid & wsel;
          s.w_ready  = w_ready_mux;
        end
        W_RESP: begin
          s.b_valid  = b_valid_mux;
          m0.b_ready = s.b_ready & ~wsel;
          m1.b_ready = s.b_ready & wsel;
        end
        default: ;
      endcase
    end
  end

endmodule
